id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register that decodes opcode/funct into the 6-bit ALU operation code and selects the ALU's two operands.
- Forwarding muxes sit on the EX side and take results from EX/MEM and MEM/WB.
- Detects load-use hazards, inserts bubbles, and stalls ID.
- Feeds i_a / i_b / i_op of the execute-stage ALU directly; EX/MEM consumes the destination and control outputs.

Parameters:
N_BITS, 32, datapath width
N_REG, 5, register address width

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_valid  in  1  ID holds a real instruction
i_stall  in  1  downstream hold; EX register keeps its contents
i_flush  in  1  branch flush; EX register loads a bubble
i_opcode  in  6  instruction [31:26]
i_funct  in  6  instruction [5:0]
i_shamt  in  5  instruction [10:6]
i_imm  in  16  instruction [15:0]
i_rs_addr / i_rt_addr / i_rd_addr  in  N_REG each  register fields
i_rs_data / i_rt_data  in  N_BITS each  register file read data
i_exmem_wr, i_exmem_rd, i_exmem_res  in  1/N_REG/N_BITS  EX/MEM writeback info
i_memwb_wr, i_memwb_rd, i_memwb_res  in  1/N_REG/N_BITS  MEM/WB writeback info
o_alu_a, o_alu_b  out  N_BITS each  ALU operands (after forwarding)
o_alu_op  out  6  ALU operation code
o_valid  out  1  EX holds a real instruction
o_reg_write  out  1  instruction writes the register file
o_wr_addr  out  N_REG  destination register
o_mem_read, o_mem_write  out  1 each  load / store
o_store_data  out  N_BITS  rt value after forwarding
o_illegal  out  1  registered flag: unsupported opcode or funct
o_load_use  out  1  combinational; ID/IF must hold

Behaviour:
- Reset value of every registered field is a bubble:
  - valid, reg_write, mem_read, mem_write, illegal = 0
  - op = 100000 (ADD)
  - data = 0, addresses = 0
  - so o_alu_a = o_alu_b = 0.
- Register update priority per rising edge: reset > i_flush (bubble) > i_stall (hold) > o_load_use (bubble) > capture.
  - Capture with i_valid=0 loads a bubble.
- Decode at capture.
  - R-type (opcode 000000):
    - funct 100000/100010/100100/100101/100110/100111: op=funct, a=rs, b=rt, wr=rd.
    - 000010 SRL / 000011 SRA: op=funct, a=rt, b=zero-extended shamt.
    - 000110 SRLV -> op 000010; 000111 SRAV -> op 000011; a=rt, b=rs.
  - ADDI 001000: op ADD, b=sign-ext imm, wr=rt.
  - ANDI 001100 / ORI 001101 / XORI 001110: op AND/OR/XOR, b=zero-ext imm, wr=rt.
  - LW 100011: op ADD, a=rs, b=sign-ext imm, mem_read=1, wr=rt.
  - SW 101011: op ADD, sign-ext imm, mem_write=1, reg_write=0.
  - BEQ 000100: op SUB (100010), a=rs, b=rt, no writes.
  - Anything else: illegal=1, op ADD, reg_write/mem_* = 0, valid kept.
- Forwarding is combinational on the registered rs/rt addresses.
  - EX/MEM wins over MEM/WB.
  - A source is forwarded only when the matching _wr is 1 and the address is non-zero.
  - Register 0 is never forwarded.
  - Forwarded rs/rt replace the register values before operand selection and before o_store_data.
  - Immediate and shamt operands are never forwarded.
- Load-use hazard: o_load_use = i_valid & o_valid & o_mem_read & (o_wr_addr != 0) & (o_wr_addr == i_rs_addr | o_wr_addr == i_rt_addr).
  - Fires regardless of whether the ID instruction actually reads rt.
  - Exactly one bubble is inserted, then the instruction is captured with the load result coming through the MEM/WB forward.
- Latency: one cycle from the ID fields to registered EX; forwarding adds zero cycles.
- Reset mid-stall clears to a bubble immediately (asynchronous).

Optional Feature:
ID_EX_PERF_CNT_EN
- Defined: adds output o_bubble_cnt [31:0].
  - Reset 0.
  - Increments by 1 on each edge where a bubble is loaded due to i_flush or o_load_use while not in reset.
  - Wraps 0xFFFFFFFF -> 0.
  - Does not count i_valid=0 captures.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then hold i_reset=1 -> o_valid=0, o_alu_op=100000, o_alu_a=o_alu_b=0.
- Capture ADDI rs=1 (data 5), imm 0xFFFF -> next cycle o_alu_a=5, o_alu_b=0xFFFFFFFF, op 100000, o_wr_addr=rt, o_reg_write=1.
- Capture SRA rt=2 (data 0x80000000), shamt 4 -> o_alu_a=0x80000000, o_alu_b=4, op 000011.
- EX holds R-type rs=3, rt=3 (both register values 1); i_exmem wr=1, rd=3, res=7; i_memwb wr=1, rd=3, res=9 -> o_alu_a=o_alu_b=7; same with rd=0 -> both 1.
- EX holds LW wr=4; ID holds ADD rs=4 -> o_load_use=1, next edge bubble (o_valid=0), following edge ADD captured; with MEM/WB res=0x1234 -> o_alu_a=0x1234.
- i_flush and i_stall asserted together -> bubble loaded; i_stall alone for 3 cycles -> outputs unchanged; opcode 111111 -> o_illegal=1, o_reg_write=0.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: decodes opcode/funct into the ALU op, forwards EX/MEM and MEM/WB
// results into the operands, and inserts a bubble on load-use. Optional: ID_EX_PERF_CNT_EN.
module id_ex_operand_stage #(
    parameter int unsigned N_BITS = 32,
    parameter int unsigned N_REG  = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [5:0]        i_opcode,
    input  logic [5:0]        i_funct,
    input  logic [4:0]        i_shamt,
    input  logic [15:0]       i_imm,
    input  logic [N_REG-1:0]  i_rs_addr,
    input  logic [N_REG-1:0]  i_rt_addr,
    input  logic [N_REG-1:0]  i_rd_addr,
    input  logic [N_BITS-1:0] i_rs_data,
    input  logic [N_BITS-1:0] i_rt_data,
    input  logic              i_exmem_wr,
    input  logic [N_REG-1:0]  i_exmem_rd,
    input  logic [N_BITS-1:0] i_exmem_res,
    input  logic              i_memwb_wr,
    input  logic [N_REG-1:0]  i_memwb_rd,
    input  logic [N_BITS-1:0] i_memwb_res,
    output logic [N_BITS-1:0] o_alu_a,
    output logic [N_BITS-1:0] o_alu_b,
    output logic [5:0]        o_alu_op,
    output logic              o_valid,
    output logic              o_reg_write,
    output logic [N_REG-1:0]  o_wr_addr,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [N_BITS-1:0] o_store_data,
    output logic              o_illegal,
    output logic              o_load_use
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       o_bubble_cnt
`endif
);

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    localparam logic [1:0] B_RT  = 2'd0;
    localparam logic [1:0] B_RS  = 2'd1;
    localparam logic [1:0] B_IMM = 2'd2;

    // EX-side registered fields
    logic              q_valid, q_rw, q_mr, q_mw, q_ill, q_a_rt;
    logic [5:0]        q_op;
    logic [1:0]        q_b_sel;
    logic [N_REG-1:0]  q_wr, q_rs_addr, q_rt_addr;
    logic [N_BITS-1:0] q_imm, q_rs_data, q_rt_data;

    logic              n_valid, n_rw, n_mr, n_mw, n_ill, n_a_rt;
    logic [5:0]        n_op;
    logic [1:0]        n_b_sel;
    logic [N_REG-1:0]  n_wr, n_rs_addr, n_rt_addr;
    logic [N_BITS-1:0] n_imm, n_rs_data, n_rt_data;

    logic              d_rw, d_mr, d_mw, d_ill, d_a_rt;
    logic [5:0]        d_op;
    logic [1:0]        d_b_sel;
    logic [N_REG-1:0]  d_wr;
    logic [N_BITS-1:0] d_imm;

    logic [N_BITS-1:0] imm_sext, imm_zext, fwd_rs, fwd_rt;
    logic              bubble_evt;

    assign imm_sext = {{(N_BITS-16){i_imm[15]}}, i_imm};
    assign imm_zext = N_BITS'(i_imm);

    // Instruction decode of the ID fields
    always_comb begin
        d_op    = OP_ADD;
        d_a_rt  = 1'b0;
        d_b_sel = B_RT;
        d_imm   = '0;
        d_wr    = '0;
        d_rw    = 1'b0;
        d_mr    = 1'b0;
        d_mw    = 1'b0;
        d_ill   = 1'b0;
        case (i_opcode)
            6'b000000: begin
                case (i_funct)
                    6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111: begin
                        d_op = i_funct;
                        d_wr = i_rd_addr;
                        d_rw = 1'b1;
                    end
                    6'b000010, 6'b000011: begin
                        d_op    = i_funct;
                        d_a_rt  = 1'b1;
                        d_b_sel = B_IMM;
                        d_imm   = N_BITS'(i_shamt);
                        d_wr    = i_rd_addr;
                        d_rw    = 1'b1;
                    end
                    6'b000110, 6'b000111: begin
                        d_op    = (i_funct == 6'b000110) ? OP_SRL : OP_SRA;
                        d_a_rt  = 1'b1;
                        d_b_sel = B_RS;
                        d_wr    = i_rd_addr;
                        d_rw    = 1'b1;
                    end
                    default: d_ill = 1'b1;
                endcase
            end
            6'b001000: begin
                d_b_sel = B_IMM;
                d_imm   = imm_sext;
                d_wr    = i_rt_addr;
                d_rw    = 1'b1;
            end
            6'b001100, 6'b001101, 6'b001110: begin
                d_op    = (i_opcode == 6'b001100) ? OP_AND :
                          (i_opcode == 6'b001101) ? OP_OR  : OP_XOR;
                d_b_sel = B_IMM;
                d_imm   = imm_zext;
                d_wr    = i_rt_addr;
                d_rw    = 1'b1;
            end
            6'b100011: begin
                d_b_sel = B_IMM;
                d_imm   = imm_sext;
                d_wr    = i_rt_addr;
                d_rw    = 1'b1;
                d_mr    = 1'b1;
            end
            6'b101011: begin
                d_b_sel = B_IMM;
                d_imm   = imm_sext;
                d_mw    = 1'b1;
            end
            6'b000100: d_op = OP_SUB;
            default:   d_ill = 1'b1;
        endcase
    end

    assign o_load_use = i_valid & q_valid & q_mr & (q_wr != '0) &
                        ((q_wr == i_rs_addr) | (q_wr == i_rt_addr));

    // Register update: flush > stall > load-use bubble > capture
    always_comb begin
        n_valid   = q_valid;
        n_op      = q_op;
        n_rw      = q_rw;
        n_wr      = q_wr;
        n_mr      = q_mr;
        n_mw      = q_mw;
        n_ill     = q_ill;
        n_a_rt    = q_a_rt;
        n_b_sel   = q_b_sel;
        n_imm     = q_imm;
        n_rs_addr = q_rs_addr;
        n_rt_addr = q_rt_addr;
        n_rs_data = q_rs_data;
        n_rt_data = q_rt_data;
        if (i_flush || (!i_stall && (o_load_use || !i_valid))) begin
            n_valid   = 1'b0;
            n_op      = OP_ADD;
            n_rw      = 1'b0;
            n_wr      = '0;
            n_mr      = 1'b0;
            n_mw      = 1'b0;
            n_ill     = 1'b0;
            n_a_rt    = 1'b0;
            n_b_sel   = B_RT;
            n_imm     = '0;
            n_rs_addr = '0;
            n_rt_addr = '0;
            n_rs_data = '0;
            n_rt_data = '0;
        end else if (!i_stall) begin
            n_valid   = 1'b1;
            n_op      = d_op;
            n_rw      = d_rw;
            n_wr      = d_wr;
            n_mr      = d_mr;
            n_mw      = d_mw;
            n_ill     = d_ill;
            n_a_rt    = d_a_rt;
            n_b_sel   = d_b_sel;
            n_imm     = d_imm;
            n_rs_addr = i_rs_addr;
            n_rt_addr = i_rt_addr;
            n_rs_data = i_rs_data;
            n_rt_data = i_rt_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            q_valid   <= 1'b0;
            q_op      <= OP_ADD;
            q_rw      <= 1'b0;
            q_wr      <= '0;
            q_mr      <= 1'b0;
            q_mw      <= 1'b0;
            q_ill     <= 1'b0;
            q_a_rt    <= 1'b0;
            q_b_sel   <= B_RT;
            q_imm     <= '0;
            q_rs_addr <= '0;
            q_rt_addr <= '0;
            q_rs_data <= '0;
            q_rt_data <= '0;
        end else begin
            q_valid   <= n_valid;
            q_op      <= n_op;
            q_rw      <= n_rw;
            q_wr      <= n_wr;
            q_mr      <= n_mr;
            q_mw      <= n_mw;
            q_ill     <= n_ill;
            q_a_rt    <= n_a_rt;
            q_b_sel   <= n_b_sel;
            q_imm     <= n_imm;
            q_rs_addr <= n_rs_addr;
            q_rt_addr <= n_rt_addr;
            q_rs_data <= n_rs_data;
            q_rt_data <= n_rt_data;
        end
    end

    // EX-side forwarding; register 0 is never forwarded
    always_comb begin
        fwd_rs = q_rs_data;
        if (i_exmem_wr && (i_exmem_rd != '0) && (i_exmem_rd == q_rs_addr))
            fwd_rs = i_exmem_res;
        else if (i_memwb_wr && (i_memwb_rd != '0) && (i_memwb_rd == q_rs_addr))
            fwd_rs = i_memwb_res;
        fwd_rt = q_rt_data;
        if (i_exmem_wr && (i_exmem_rd != '0) && (i_exmem_rd == q_rt_addr))
            fwd_rt = i_exmem_res;
        else if (i_memwb_wr && (i_memwb_rd != '0) && (i_memwb_rd == q_rt_addr))
            fwd_rt = i_memwb_res;
    end

    always_comb begin
        o_alu_a = q_a_rt ? fwd_rt : fwd_rs;
        case (q_b_sel)
            B_RS:    o_alu_b = fwd_rs;
            B_IMM:   o_alu_b = q_imm;
            default: o_alu_b = fwd_rt;
        endcase
    end

    assign o_alu_op     = q_op;
    assign o_valid      = q_valid;
    assign o_reg_write  = q_rw;
    assign o_wr_addr    = q_wr;
    assign o_mem_read   = q_mr;
    assign o_mem_write  = q_mw;
    assign o_store_data = fwd_rt;
    assign o_illegal    = q_ill;

    assign bubble_evt = i_flush | (!i_stall & o_load_use);

`ifdef ID_EX_PERF_CNT_EN
    // Counts flush and load-use bubbles only, not idle captures
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            o_bubble_cnt <= '0;
        else if (bubble_evt)
            o_bubble_cnt <= o_bubble_cnt + 32'd1;
    end
`else
    logic unused_bubble;
    assign unused_bubble = bubble_evt;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage; also covers o_bubble_cnt when ID_EX_PERF_CNT_EN is set.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset, valid, stall, flush;
    logic [5:0]  opcode, funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [31:0] rs_data, rt_data;
    logic        exmem_wr, memwb_wr;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_res, memwb_res;
    logic [31:0] alu_a, alu_b, store_data;
    logic [5:0]  alu_op;
    logic        out_valid, reg_write, mem_read, mem_write, illegal, load_use;
    logic [4:0]  wr_addr;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic        v;
        logic [5:0]  op;
        logic [31:0] a, b, sd;
        logic        rw, mr, mw, ill;
        logic [4:0]  wr;
        bit          chk_ab, chk_wr;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_opcode(opcode), .i_funct(funct), .i_shamt(shamt), .i_imm(imm),
        .i_rs_addr(rs_addr), .i_rt_addr(rt_addr), .i_rd_addr(rd_addr),
        .i_rs_data(rs_data), .i_rt_data(rt_data),
        .i_exmem_wr(exmem_wr), .i_exmem_rd(exmem_rd), .i_exmem_res(exmem_res),
        .i_memwb_wr(memwb_wr), .i_memwb_rd(memwb_rd), .i_memwb_res(memwb_res),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .o_valid(out_valid),
        .o_reg_write(reg_write), .o_wr_addr(wr_addr), .o_mem_read(mem_read),
        .o_mem_write(mem_write), .o_store_data(store_data), .o_illegal(illegal),
        .o_load_use(load_use)
`ifdef ID_EX_PERF_CNT_EN
        , .o_bubble_cnt(bubble_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic v, input logic [5:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic rw, input logic [4:0] wr, input logic mr,
                                input logic mw, input logic [31:0] sd, input logic ill);
        exp_t e;
        e.tag = tag; e.v = v; e.op = op; e.a = a; e.b = b; e.rw = rw; e.wr = wr;
        e.mr = mr; e.mw = mw; e.sd = sd; e.ill = ill; e.chk_ab = 1'b1; e.chk_wr = 1'b1;
        return e;
    endfunction

    function automatic exp_t bubble(input string tag);
        return mk(tag, 1'b0, 6'b100000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    endfunction

    task automatic compare(input exp_t e);
        check({e.tag, ".valid"}, 32'(out_valid), 32'(e.v));
        check({e.tag, ".op"}, 32'(alu_op), 32'(e.op));
        check({e.tag, ".reg_write"}, 32'(reg_write), 32'(e.rw));
        check({e.tag, ".mem_read"}, 32'(mem_read), 32'(e.mr));
        check({e.tag, ".mem_write"}, 32'(mem_write), 32'(e.mw));
        check({e.tag, ".illegal"}, 32'(illegal), 32'(e.ill));
        if (e.chk_wr) check({e.tag, ".wr_addr"}, 32'(wr_addr), 32'(e.wr));
        if (e.chk_ab) begin
            check({e.tag, ".alu_a"}, alu_a, e.a);
            check({e.tag, ".alu_b"}, alu_b, e.b);
            check({e.tag, ".store_data"}, store_data, e.sd);
        end
    endtask

    // Push the expectation, clock once, then pop and compare away from the edge
    task automatic step(input exp_t e);
        exp_t got;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        compare(got);
    endtask

    task automatic set_id(input logic v, input logic [5:0] opc, input logic [5:0] fn,
                          input logic [4:0] sh, input logic [15:0] im,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd);
        valid = v; opcode = opc; funct = fn; shamt = sh; imm = im;
        rs_addr = rs; rt_addr = rt; rd_addr = rd; rs_data = rsd; rt_data = rtd;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] eres,
                           input logic mw, input logic [4:0] mr, input logic [31:0] mres);
        exmem_wr = ew; exmem_rd = er; exmem_res = eres;
        memwb_wr = mw; memwb_rd = mr; memwb_res = mres;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        set_id(1'b0, 6'd0, 6'd0, 5'd0, 16'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2;
        step(bubble("reset"));
        set_id(1'b1, 6'b001000, 6'd0, 5'd0, 16'hFFFF, 5'd1, 5'd6, 5'd0, 32'd5, 32'h11);
        step(bubble("reset_hold"));
        reset = 1'b0;

        step(mk("addi", 1, 6'b100000, 32'd5, 32'hFFFFFFFF, 1, 5'd6, 0, 0, 32'h11, 0));
        set_id(1'b1, 6'b000000, 6'b000011, 5'd4, 16'h0, 5'd7, 5'd2, 5'd9, 32'd3, 32'h80000000);
        step(mk("sra", 1, 6'b000011, 32'h80000000, 32'd4, 1, 5'd9, 0, 0, 32'h80000000, 0));
        funct = 6'b000111;
        step(mk("srav", 1, 6'b000011, 32'h80000000, 32'd3, 1, 5'd9, 0, 0, 32'h80000000, 0));
        set_id(1'b1, 6'b001101, 6'd0, 5'd0, 16'h8000, 5'd1, 5'd8, 5'd0, 32'h0F, 32'h55);
        step(mk("ori", 1, 6'b100101, 32'h0F, 32'h00008000, 1, 5'd8, 0, 0, 32'h55, 0));

        set_id(1'b1, 6'b101011, 6'd0, 5'd0, 16'hFFFC, 5'd1, 5'd2, 5'd0, 32'h40, 32'hAB);
        e = mk("sw", 1, 6'b100000, 32'h40, 32'hFFFFFFFC, 0, 5'd0, 0, 1, 32'hAB, 0);
        e.chk_wr = 1'b0;
        step(e);
        set_id(1'b1, 6'b000100, 6'd0, 5'd0, 16'h0, 5'd1, 5'd2, 5'd0, 32'h10, 32'h10);
        e = mk("beq", 1, 6'b100010, 32'h10, 32'h10, 0, 5'd0, 0, 0, 32'h10, 0);
        e.chk_wr = 1'b0;
        step(e);

        // Forwarding priority, with EX held by stall while sources change
        set_id(1'b1, 6'b000000, 6'b100000, 5'd0, 16'h0, 5'd3, 5'd3, 5'd10, 32'd1, 32'd1);
        set_fwd(1'b1, 5'd3, 32'd7, 1'b1, 5'd3, 32'd9);
        step(mk("fwd_exmem", 1, 6'b100000, 32'd7, 32'd7, 1, 5'd10, 0, 0, 32'd7, 0));
        stall = 1'b1;
        set_fwd(1'b1, 5'd0, 32'd7, 1'b1, 5'd3, 32'd9);
        step(mk("fwd_memwb", 1, 6'b100000, 32'd9, 32'd9, 1, 5'd10, 0, 0, 32'd9, 0));
        set_fwd(1'b1, 5'd0, 32'd7, 1'b1, 5'd0, 32'd9);
        step(mk("fwd_r0", 1, 6'b100000, 32'd1, 32'd1, 1, 5'd10, 0, 0, 32'd1, 0));
        set_fwd(1'b0, 5'd3, 32'd7, 1'b0, 5'd3, 32'd9);
        step(mk("fwd_nowr", 1, 6'b100000, 32'd1, 32'd1, 1, 5'd10, 0, 0, 32'd1, 0));
        stall = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Load-use
        set_id(1'b1, 6'b100011, 6'd0, 5'd0, 16'h0008, 5'd1, 5'd4, 5'd0, 32'h100, 32'h0);
        step(mk("lw", 1, 6'b100000, 32'h100, 32'd8, 1, 5'd4, 1, 0, 32'h0, 0));
        set_id(1'b1, 6'b001000, 6'd0, 5'd0, 16'h1, 5'd1, 5'd4, 5'd0, 32'd0, 32'd0);
        #1 check("load_use_rt", 32'(load_use), 32'd1);
        valid = 1'b0;
        #1 check("load_use_idle", 32'(load_use), 32'd0);
        set_id(1'b1, 6'b000000, 6'b100000, 5'd0, 16'h0, 5'd4, 5'd5, 5'd11, 32'd0, 32'd2);
        #1 check("load_use_rs", 32'(load_use), 32'd1);
        step(bubble("lu_bubble"));
        check("load_use_after", 32'(load_use), 32'd0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h1234);
        step(mk("lu_capture", 1, 6'b100000, 32'h1234, 32'd2, 1, 5'd11, 0, 0, 32'd2, 0));
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Flush beats stall
        set_id(1'b1, 6'b001000, 6'd0, 5'd0, 16'h3, 5'd1, 5'd6, 5'd0, 32'd5, 32'd0);
        flush = 1'b1; stall = 1'b1;
        step(bubble("flush_stall"));
        flush = 1'b0; stall = 1'b0;
        step(mk("addi2", 1, 6'b100000, 32'd5, 32'd3, 1, 5'd6, 0, 0, 32'd0, 0));
        stall = 1'b1;
        set_id(1'b1, 6'b111111, 6'd0, 5'd0, 16'h7, 5'd2, 5'd3, 5'd0, 32'hDEAD, 32'hBEEF);
        for (int i = 0; i < 3; i++)
            step(mk($sformatf("stall%0d", i), 1, 6'b100000, 32'd5, 32'd3, 1, 5'd6, 0, 0, 32'd0, 0));
        stall = 1'b0;
        e = mk("illegal", 1, 6'b100000, 32'h0, 32'h0, 0, 5'd0, 0, 0, 32'h0, 1);
        e.chk_ab = 1'b0; e.chk_wr = 1'b0;
        step(e);
        valid = 1'b0;
        step(bubble("idle_capture"));
`ifdef ID_EX_PERF_CNT_EN
        check("bubble_cnt", bubble_cnt, 32'd2);
`endif

        // Asynchronous reset during a stall
        set_id(1'b1, 6'b001000, 6'd0, 5'd0, 16'h3, 5'd1, 5'd6, 5'd0, 32'd5, 32'd0);
        step(mk("pre_reset", 1, 6'b100000, 32'd5, 32'd3, 1, 5'd6, 0, 0, 32'd0, 0));
        stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        compare(bubble("async_reset"));
`ifdef ID_EX_PERF_CNT_EN
        check("bubble_cnt_reset", bubble_cnt, 32'd0);
`endif
        #2 reset = 1'b0;
        stall = 1'b0; valid = 1'b0;
        step(bubble("post_reset"));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
